axis_rr_arbiter: RTL and testbench

//  - N-to-1 AXI-Stream round-robin arbiter that shares one streaming datapath (the delay/process

---
 rtl/axis_rr_arbiter_pkg.sv | 23 ++
 rtl/axis_skid_reg.sv | 52 +++++
 rtl/axis_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice. Input ready is taken straight from a
// flop, so there is no combinational path from m_ready to s_ready.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_vld_q;
  logic             skid_vld_q;

  assign s_ready = ~skid_vld_q;
  assign m_valid = main_vld_q;
  assign m_data  = main_q;

  // The skid entry only fills when the output stalls while a beat arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (skid_vld_q) begin
        if (m_ready) begin
          main_q     <= skid_q;
          skid_vld_q <= 1'b0;
        end
      end else if (s_valid) begin
        if (!main_vld_q || m_ready) begin
          main_q     <= s_data;
          main_vld_q <= 1'b1;
        end else begin
          skid_q     <= s_data;
          skid_vld_q <= 1'b1;
        end
      end else if (m_ready) begin
        main_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream round-robin arbiter with packet or beat granularity grants.
//   state | meaning
//   IDLE  | no owner; scan requesters from rr_ptr+1 and latch the winner
//   BUSY  | grant_idx owns the skid stage until release (tlast or every beat)
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int PORTS      = 4,
  parameter int ID_WIDTH   = clog2(PORTS),
  parameter int ARB_LAST   = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [ID_WIDTH-1:0]         m_axis_tid,
  output logic                        grant_active,
  output logic [ID_WIDTH-1:0]         grant_idx
);

  localparam int PAYLOAD_W = DATA_WIDTH + ID_WIDTH + 1;
  localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(PORTS - 1);
  localparam logic [ID_WIDTH:0]   PORTS_W   = (ID_WIDTH + 1)'(PORTS);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [ID_WIDTH-1:0]   start_idx;
  logic [2*PORTS-1:0]    req_dbl;
  logic [PORTS-1:0]      req_rot;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_off;
  logic [ID_WIDTH:0]     pick_sum;
  logic [ID_WIDTH-1:0]   pick_idx;

  logic [DATA_WIDTH-1:0] lane_data;
  logic                  lane_valid;
  logic                  lane_last;

  logic                  busy;
  logic                  skid_s_ready;
  logic                  beat_acc;
  logic                  grant_release;
  logic [PAYLOAD_W-1:0]  skid_in;
  logic [PAYLOAD_W-1:0]  skid_out;

  assign busy = (state_q == BUSY);

  // Rotate requests so bit 0 is the lane just after the last winner.
  assign start_idx = (rr_ptr_q == LAST_PORT) ? '0 : rr_ptr_q + 1'b1;
  assign req_dbl   = {s_axis_tvalid, s_axis_tvalid} >> start_idx;
  assign req_rot   = req_dbl[PORTS-1:0];

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        pick_off   = ID_WIDTH'(k);
      end
    end
  end

  assign pick_sum = {1'b0, start_idx} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= PORTS_W) ? ID_WIDTH'(pick_sum - PORTS_W)
                                          : pick_sum[ID_WIDTH-1:0];

  always_comb begin
    lane_data  = '0;
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        lane_data  = s_axis_tdata[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
        lane_valid = s_axis_tvalid[i];
        lane_last  = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (busy) begin
      for (int i = 0; i < PORTS; i++) begin
        s_axis_tready[i] = (grant_q == ID_WIDTH'(i)) && skid_s_ready;
      end
    end
  end

  assign beat_acc      = busy && lane_valid && skid_s_ready;
  assign grant_release = beat_acc && ((ARB_LAST == 0) || lane_last);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (grant_release) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= LAST_PORT;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign skid_in = {grant_q, lane_last, lane_data};

  axis_skid_reg #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .s_valid (busy && lane_valid),
    .s_ready (skid_s_ready),
    .s_data  (skid_in),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (skid_out)
  );

  assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = skid_out;
  assign grant_active = busy;
  assign grant_idx    = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: packet mode (4 ports), beat mode (4 ports)
// and a 3-port packet-mode instance, each checked against hand-computed beat lists.
module tb_axis_rr_arbiter;

  localparam int DW = 16;
  localparam int ND = 3;

  typedef struct packed {
    logic [1:0]    tid;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [3:0]      s_valid_a, s_last_a, s_ready_a;
  logic [4*DW-1:0] s_data_a;
  logic            m_valid_a, m_ready_a, m_last_a, g_act_a;
  logic [DW-1:0]   m_data_a;
  logic [1:0]      m_tid_a, g_idx_a;

  logic [3:0]      s_valid_b, s_last_b, s_ready_b;
  logic [4*DW-1:0] s_data_b;
  logic            m_valid_b, m_ready_b, m_last_b, g_act_b;
  logic [DW-1:0]   m_data_b;
  logic [1:0]      m_tid_b, g_idx_b;

  logic [2:0]      s_valid_c, s_last_c, s_ready_c;
  logic [3*DW-1:0] s_data_c;
  logic            m_valid_c, m_ready_c, m_last_c, g_act_c;
  logic [DW-1:0]   m_data_c;
  logic [1:0]      m_tid_c, g_idx_c;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .PORTS(4), .ID_WIDTH(2), .ARB_LAST(1)) u_dut_a (
    .clock(clk), .reset(rst),
    .s_axis_tdata(s_data_a), .s_axis_tvalid(s_valid_a), .s_axis_tready(s_ready_a),
    .s_axis_tlast(s_last_a), .m_axis_tdata(m_data_a), .m_axis_tvalid(m_valid_a),
    .m_axis_tready(m_ready_a), .m_axis_tlast(m_last_a), .m_axis_tid(m_tid_a),
    .grant_active(g_act_a), .grant_idx(g_idx_a)
  );

  axis_rr_arbiter #(.DATA_WIDTH(DW), .PORTS(4), .ID_WIDTH(2), .ARB_LAST(0)) u_dut_b (
    .clock(clk), .reset(rst),
    .s_axis_tdata(s_data_b), .s_axis_tvalid(s_valid_b), .s_axis_tready(s_ready_b),
    .s_axis_tlast(s_last_b), .m_axis_tdata(m_data_b), .m_axis_tvalid(m_valid_b),
    .m_axis_tready(m_ready_b), .m_axis_tlast(m_last_b), .m_axis_tid(m_tid_b),
    .grant_active(g_act_b), .grant_idx(g_idx_b)
  );

  axis_rr_arbiter #(.DATA_WIDTH(DW), .PORTS(3), .ID_WIDTH(2), .ARB_LAST(1)) u_dut_c (
    .clock(clk), .reset(rst),
    .s_axis_tdata(s_data_c), .s_axis_tvalid(s_valid_c), .s_axis_tready(s_ready_c),
    .s_axis_tlast(s_last_c), .m_axis_tdata(m_data_c), .m_axis_tvalid(m_valid_c),
    .m_axis_tready(m_ready_c), .m_axis_tlast(m_last_c), .m_axis_tid(m_tid_c),
    .grant_active(g_act_c), .grant_idx(g_idx_c)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [DW:0] lane_q  [ND][4][$];
  logic [3:0]  en      [ND];
  beat_t       log_q   [ND][$];
  int          log_cyc [ND][$];
  beat_t       exp_q   [$];
  beat_t       obs_b   [ND];
  logic        obs_v   [ND];
  logic [3:0]  obs_rdy [ND];
  logic [2:0]  obs_g   [ND];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int lane, input int pkt, input int bt, input logic last);
    beat_t b;
    b.tid  = 2'(lane);
    b.last = last;
    b.data = {4'(lane), 4'(pkt), 8'(bt)};
    return b;
  endfunction

  task automatic push_pkt(input int d, input int lane, input int pkt, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b = mk(lane, pkt, k, k == n - 1);
      lane_q[d][lane].push_back({b.last, b.data});
    end
  endtask

  task automatic exp_pkt(input int lane, input int pkt, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(lane, pkt, k, k == n - 1));
  endtask

  function automatic logic mr(input int d);
    case (d)
      0:       return m_ready_a;
      1:       return m_ready_b;
      default: return m_ready_c;
    endcase
  endfunction

  function automatic logic [3:0] cur_valid(input int d);
    case (d)
      0:       return s_valid_a;
      1:       return s_valid_b;
      default: return {1'b0, s_valid_c};
    endcase
  endfunction

  task automatic sample(input int d, output beat_t b, output logic v,
                        output logic [3:0] rdy, output logic [2:0] g);
    case (d)
      0: begin
        b = {m_tid_a, m_last_a, m_data_a}; v = m_valid_a;
        rdy = s_ready_a; g = {g_act_a, g_idx_a};
      end
      1: begin
        b = {m_tid_b, m_last_b, m_data_b}; v = m_valid_b;
        rdy = s_ready_b; g = {g_act_b, g_idx_b};
      end
      default: begin
        b = {m_tid_c, m_last_c, m_data_c}; v = m_valid_c;
        rdy = {1'b0, s_ready_c}; g = {g_act_c, g_idx_c};
      end
    endcase
  endtask

  task automatic drive();
    logic [3:0]      v, l;
    logic [4*DW-1:0] dt;
    logic [DW:0]     f;
    for (int d = 0; d < ND; d++) begin
      v = '0; l = '0; dt = '0;
      for (int i = 0; i < 4; i++) begin
        if (lane_q[d][i].size() > 0) begin
          f = lane_q[d][i][0];
          v[i] = en[d][i];
          l[i] = f[DW];
          dt[i*DW +: DW] = f[DW-1:0];
        end
      end
      case (d)
        0:       begin s_valid_a = v; s_last_a = l; s_data_a = dt; end
        1:       begin s_valid_b = v; s_last_b = l; s_data_b = dt; end
        default: begin s_valid_c = v[2:0]; s_last_c = l[2:0]; s_data_c = dt[3*DW-1:0]; end
      endcase
    end
  endtask

  // One cycle: observe at the falling edge, retire handshaken beats after the rising edge.
  task automatic step();
    logic [3:0] hs [ND];
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      sample(d, obs_b[d], obs_v[d], obs_rdy[d], obs_g[d]);
      hs[d] = cur_valid(d) & obs_rdy[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 4; i++)
        if (hs[d][i] && lane_q[d][i].size() > 0) void'(lane_q[d][i].pop_front());
    drive();
  endtask

  task automatic run_until(input int d, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_q[d].size() < n && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_count"}, 64'(log_q[d].size()), 64'(n));
  endtask

  task automatic chk_log(input int d, input int base, input string tag);
    beat_t got;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (base + k < log_q[d].size()) ? log_q[d][base + k] : '0;
      chk($sformatf("%s_beat%0d", tag, k), 64'(got), 64'(exp_q[k]));
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t      b;
    logic       v;
    logic [3:0] r;
    logic [2:0] g;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      sample(d, b, v, r, g);
      if (v && mr(d)) begin
        log_q[d].push_back(b);
        log_cyc[d].push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int    base;
    beat_t held;
    logic  held_v, stable, rdy2;

    rst = 1'b1;
    m_ready_a = 1'b1; m_ready_b = 1'b1; m_ready_c = 1'b1;
    for (int d = 0; d < ND; d++) en[d] = 4'hF;
    drive();

    // Reset state
    @(negedge clk);
    sample(0, obs_b[0], obs_v[0], obs_rdy[0], obs_g[0]);
    chk("rst_m_valid", 64'(obs_v[0]), 64'd0);
    chk("rst_s_ready", 64'(obs_rdy[0]), 64'd0);
    chk("rst_grant", 64'(obs_g[0]), 64'd0);
    chk("rst_m_beat", 64'(obs_b[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fairness, 3-beat packets, one bubble between packets
    for (int i = 0; i < 4; i++) push_pkt(0, i, 0, 3);
    push_pkt(0, 0, 1, 3);
    drive();
    run_until(0, 15, 200, "t2");
    exp_q.delete();
    exp_pkt(0, 0, 3); exp_pkt(1, 0, 3); exp_pkt(2, 0, 3); exp_pkt(3, 0, 3); exp_pkt(0, 1, 3);
    chk_log(0, 0, "t2");
    chk("t2_burst", 64'(log_cyc[0][1] - log_cyc[0][0]), 64'd1);
    chk("t2_gap", 64'(log_cyc[0][3] - log_cyc[0][2]), 64'd2);

    // Reset mid-packet on lane 1
    for (int i = 0; i < 4; i++) push_pkt(0, i, 2, 3);
    drive();
    repeat (3) step();
    chk("t1_pre_grant", 64'(obs_g[0]), 64'b101);
    rst = 1'b1;
    @(negedge clk);
    sample(0, obs_b[0], obs_v[0], obs_rdy[0], obs_g[0]);
    chk("t1_rst_m_valid", 64'(obs_v[0]), 64'd0);
    chk("t1_rst_s_ready", 64'(obs_rdy[0]), 64'd0);
    chk("t1_rst_grant", 64'(obs_g[0]), 64'd0);
    chk("t1_rst_m_beat", 64'(obs_b[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      lane_q[0][i].delete();
      push_pkt(0, i, 3, 3);
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    base = log_q[0].size();
    run_until(0, base + 3, 50, "t1_first");
    exp_q.delete();
    exp_pkt(0, 3, 3);
    chk_log(0, base, "t1");
    run_until(0, base + 12, 100, "t1_drain");

    // Backpressure mid-packet on lane 2
    base = log_q[0].size();
    push_pkt(0, 2, 4, 6);
    drive();
    run_until(0, base + 2, 50, "t3_pre");
    m_ready_a = 1'b0;
    stable = 1'b1; held = '0; held_v = 1'b0; rdy2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        held   = obs_b[0];
        held_v = obs_v[0];
      end else if (obs_b[0] !== held || obs_v[0] !== 1'b1) begin
        stable = 1'b0;
      end
      if (k == 1) rdy2 = obs_rdy[0][2];
    end
    chk("t3_held_valid", 64'(held_v), 64'd1);
    chk("t3_stable", 64'(stable), 64'd1);
    chk("t3_tready_drop", 64'(rdy2), 64'd0);
    m_ready_a = 1'b1;
    run_until(0, base + 6, 60, "t3");
    exp_q.delete();
    exp_pkt(2, 4, 6);
    chk_log(0, base, "t3");
    repeat (4) step();
    chk("t3_nodup", 64'(log_q[0].size()), 64'(base + 6));

    // Lane 1 drops tvalid mid-packet while lane 3 waits
    base = log_q[0].size();
    push_pkt(0, 1, 5, 4);
    drive();
    run_until(0, base + 2, 50, "t4_pre");
    push_pkt(0, 3, 5, 2);
    en[0][1] = 1'b0;
    drive();
    repeat (4) step();
    chk("t4_hold_grant", 64'(obs_g[0]), 64'b101);
    chk("t4_lane3_blocked", 64'(obs_rdy[0][3]), 64'd0);
    en[0][1] = 1'b1;
    drive();
    run_until(0, base + 6, 60, "t4");
    exp_q.delete();
    exp_pkt(1, 5, 4); exp_pkt(3, 5, 2);
    chk_log(0, base, "t4");

    // Beat-mode arbitration alternates 0,3 regardless of tlast
    push_pkt(1, 0, 6, 3);
    push_pkt(1, 3, 6, 3);
    drive();
    run_until(1, 6, 80, "t5");
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(0, 6, k, k == 2));
      exp_q.push_back(mk(3, 6, k, k == 2));
    end
    chk_log(1, 0, "t5");

    // Three ports, only lane 2 requesting: scan wraps 2 -> 0 and re-grants 2
    push_pkt(2, 2, 7, 2);
    push_pkt(2, 2, 8, 2);
    push_pkt(2, 2, 9, 2);
    drive();
    run_until(2, 6, 80, "t6");
    exp_q.delete();
    exp_pkt(2, 7, 2); exp_pkt(2, 8, 2); exp_pkt(2, 9, 2);
    chk_log(2, 0, "t6");
    step();
    chk("t6_grant_idle", 64'(obs_g[2]), 64'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
